// File: rtl/filter_border_sequencer_pkg.sv
// Shared definitions for the filter border sequencer: pixel width,
// sequencer state encoding and the kernel border-width helper.
package isp_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TOP   = 3'd1,
        LEFT  = 3'd2,
        DATA  = 3'd3,
        RIGHT = 3'd4,
        BOT   = 3'd5,
        DRAIN = 3'd6,
        DONE  = 3'd7
    } seq_state_e;

    // Zero border on each side of the image for an odd kernel side.
    function automatic int border_w(input int kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

endpackage

// File: rtl/filter_border_sequencer_if.sv
// Pixel stream and status bundle between the frame driver (master) and
// the border sequencer (slave).
interface filter_border_sequencer_if;
    import isp_pkg::*;

    logic             newFrame;
    logic             iValid;
    logic [PIX_W-1:0] iData;
    logic             oValid;
    logic [PIX_W-1:0] oData;
    logic             oBusy;
    logic             oDone;
    logic             oOverflow;
    logic             oFrameErr;

    modport master (
        output newFrame, iValid, iData,
        input  oValid, oData, oBusy, oDone, oOverflow, oFrameErr
    );

    modport slave (
        input  newFrame, iValid, iData,
        output oValid, oData, oBusy, oDone, oOverflow, oFrameErr
    );

endinterface

// File: rtl/filter_border_sequencer_fifo.sv
// Single-clock pixel FIFO. Read data appears on dout the cycle after a pop;
// dout reads zero on cycles that follow no pop, so it can feed the padded
// output stream directly (border cycles simply do not pop).
module sync_pixel_fifo #(
    parameter int DEPTH = 4096,
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic [DW-1:0] dout_q;
    logic          rd_en_s;
    logic          wr_en_s;

    // A pop in the same cycle frees a slot, so a push on full is accepted then.
    assign rd_en_s = pop && !empty;
    assign wr_en_s = push && (!full || rd_en_s);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout    = dout_q;

    // Storage write; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    // Pointer update and registered read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (rd_en_s) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                dout_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end else begin
                dout_q   <= '0;
            end
        end
    end

endmodule

// File: rtl/filter_border_sequencer.sv
// Wraps one frame of pixels in a zero border of (KERNEL_SIZE-1)/2 pixels,
// then emits DRAIN_CYCLES zero pixels so the downstream filter drains.
// Input pixels are buffered in a FIFO so they are never lost while the
// border is being emitted; the FIFO is only emptied by reset.
module filter_border_sequencer
    import isp_pkg::*;
#(
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    parameter int KERNEL_SIZE  = 7,
    parameter int DRAIN_CYCLES = 2000,
    parameter int FIFO_DEPTH   = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    filter_border_sequencer_if.slave   bus
);

    localparam int          BW         = border_w(KERNEL_SIZE);
    localparam logic [31:0] LAST_X     = 32'(WIDTH + 2*BW - 1);
    localparam logic [31:0] LEFT_LAST  = 32'(BW - 1);
    localparam logic [31:0] DATA_LAST  = 32'(BW + WIDTH - 1);
    localparam logic [31:0] TOP_LAST_Y = 32'(BW - 1);
    localparam logic [31:0] ACT_LAST_Y = 32'(BW + HEIGHT - 1);
    localparam logic [31:0] BOT_LAST_Y = 32'(HEIGHT + 2*BW - 1);
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [31:0]      x_q;
    logic [31:0]      x_d;
    logic [31:0]      y_q;
    logic [31:0]      y_d;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic             ovf_q;
    logic             ferr_q;
    logic             emit_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [PIX_W-1:0] fifo_dout_s;

    sync_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (PIX_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.iValid),
        .pop   (pop_s),
        .din   (bus.iData),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state, counter and emit/pop decisions for the padded raster walk.
    // x_q is the column in the padded row (reused as the drain counter),
    // y_q is the padded row index.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        emit_s  = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.newFrame) begin
                    state_d = TOP;
                    x_d     = 32'd0;
                    y_d     = 32'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            TOP: begin
                emit_s = 1'b1;
                if (x_q == LAST_X) begin
                    x_d = 32'd0;
                    y_d = y_q + 32'd1;
                    if (y_q == TOP_LAST_Y) begin
                        state_d = LEFT;
                    end else begin
                        state_d = TOP;
                    end
                end else begin
                    x_d = x_q + 32'd1;
                end
            end
            LEFT: begin
                emit_s = 1'b1;
                x_d    = x_q + 32'd1;
                if (x_q == LEFT_LAST) begin
                    state_d = DATA;
                end else begin
                    state_d = LEFT;
                end
            end
            DATA: begin
                // An empty FIFO stalls the walk; no border is substituted.
                if (!fifo_empty_s) begin
                    emit_s = 1'b1;
                    pop_s  = 1'b1;
                    x_d    = x_q + 32'd1;
                    if (x_q == DATA_LAST) begin
                        state_d = RIGHT;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            RIGHT: begin
                emit_s = 1'b1;
                if (x_q == LAST_X) begin
                    x_d = 32'd0;
                    y_d = y_q + 32'd1;
                    if (y_q == ACT_LAST_Y) begin
                        state_d = BOT;
                    end else begin
                        state_d = LEFT;
                    end
                end else begin
                    x_d = x_q + 32'd1;
                end
            end
            BOT: begin
                emit_s = 1'b1;
                if (x_q == LAST_X) begin
                    x_d = 32'd0;
                    if (y_q == BOT_LAST_Y) begin
                        y_d     = 32'd0;
                        state_d = DRAIN;
                    end else begin
                        y_d     = y_q + 32'd1;
                        state_d = BOT;
                    end
                end else begin
                    x_d = x_q + 32'd1;
                end
            end
            DRAIN: begin
                emit_s = 1'b1;
                if (x_q == DRAIN_LAST) begin
                    x_d     = 32'd0;
                    state_d = DONE;
                end else begin
                    x_d     = x_q + 32'd1;
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs; sticky errors clear only on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= 32'd0;
            y_q     <= 32'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            valid_q <= emit_s;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_q == DONE);
            if (bus.iValid && fifo_full_s && !pop_s) begin
                ovf_q <= 1'b1;
            end
            if (bus.newFrame && (state_q != IDLE)) begin
                ferr_q <= 1'b1;
            end
        end
    end

    assign bus.oValid    = valid_q;
    assign bus.oData     = fifo_dout_s;
    assign bus.oBusy     = busy_q;
    assign bus.oDone     = done_q;
    assign bus.oOverflow = ovf_q;
    assign bus.oFrameErr = ferr_q;

endmodule

// File: tb/tb_filter_border_sequencer.sv
// Directed bench for filter_border_sequencer with an 8x4 image, 3x3 kernel
// (1-pixel border) and 5 drain cycles; a second instance with a 4-entry
// FIFO exercises overflow.
module tb_filter_border_sequencer;
    import isp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [PIX_W-1:0] q[$];
    int done_cnt = 0;
    int gap_cnt  = 0;
    int pend     = 0;
    int seen     = 0;

    always #5 clk = ~clk;

    filter_border_sequencer_if bus ();
    filter_border_sequencer_if bus2 ();

    filter_border_sequencer #(
        .WIDTH(8), .HEIGHT(4), .KERNEL_SIZE(3), .DRAIN_CYCLES(5), .FIFO_DEPTH(64)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    filter_border_sequencer #(
        .WIDTH(8), .HEIGHT(4), .KERNEL_SIZE(3), .DRAIN_CYCLES(5), .FIFO_DEPTH(4)
    ) dut_small (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    // Output monitor: collect valid pixels, count done pulses and gaps inside the stream.
    always @(negedge clk) begin
        if (bus.oValid) begin
            q.push_back(bus.oData);
            if (seen != 0) gap_cnt += pend;
            pend = 0;
            seen = 1;
        end else if (seen != 0) begin
            pend++;
        end
        if (bus.oDone) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q.delete();
        done_cnt = 0;
        gap_cnt  = 0;
        pend     = 0;
        seen     = 0;
    endtask

    // Feed n pixels base+1..base+n, gap idle cycles after each; newFrame on
    // the first pixel if first_nf, and again on pixel index extra_nf.
    task automatic feed(input int base, input int n, input int gap,
                        input bit first_nf, input int extra_nf);
        for (int i = 0; i < n; i++) begin
            bus.iValid   = 1'b1;
            bus.iData    = 24'(base + i + 1);
            bus.newFrame = (first_nf && i == 0) || (i == extra_nf);
            tick();
            bus.iValid   = 1'b0;
            bus.newFrame = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done(input int bound);
        int g;
        g = 0;
        while (done_cnt == 0 && g < bound) begin
            tick();
            g++;
        end
        repeat (3) tick();
    endtask

    // Expected frame: 10x6 padded raster (zero ring) then 5 drain zeros.
    function automatic int frame_errs(input int base);
        int e;
        int exp;
        int pr;
        int pc;
        e = 0;
        for (int k = 0; k < 65; k++) begin
            pr = k / 10;
            pc = k % 10;
            if (k >= 60 || pr == 0 || pr == 5 || pc == 0 || pc == 9) exp = 0;
            else exp = base + (pr - 1) * 8 + pc;
            if (k >= q.size()) e++;
            else if (q[k] !== 24'(exp)) e++;
        end
        return e;
    endfunction

    task automatic check_frame(input string tag, input int base);
        chk({tag, "_count"}, 32'(q.size()), 32'd65);
        chk({tag, "_data"}, 32'(frame_errs(base)), 32'd0);
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_idle"}, 32'(bus.oBusy), 32'd0);
    endtask

    initial begin
        bus.newFrame  = 1'b0;
        bus.iValid    = 1'b0;
        bus.iData     = 24'd0;
        bus2.newFrame = 1'b0;
        bus2.iValid   = 1'b0;
        bus2.iData    = 24'd0;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(bus.oValid), 32'd0);
        chk("rst_data", 32'(bus.oData), 32'd0);
        chk("rst_busy", 32'(bus.oBusy), 32'd0);
        chk("rst_done", 32'(bus.oDone), 32'd0);
        chk("rst_ovf", 32'(bus.oOverflow), 32'd0);
        chk("rst_ferr", 32'(bus.oFrameErr), 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        clear_mon();

        // 1: back-to-back pixels
        feed(0, 32, 0, 1'b1, -1);
        chk("t1_busy_mid", 32'(bus.oBusy), 32'd1);
        wait_done(300);
        check_frame("t1", 0);
        chk("t1_gaps", 32'(gap_cnt), 32'd0);
        chk("t1_ovf", 32'(bus.oOverflow), 32'd0);
        chk("t1_ferr", 32'(bus.oFrameErr), 32'd0);

        // 2: 3 idle cycles after each pixel
        clear_mon();
        feed(0, 32, 3, 1'b1, -1);
        wait_done(300);
        check_frame("t2", 0);
        chk("t2_gaps_seen", 32'(gap_cnt > 0), 32'd1);

        // 4: newFrame pulsed during DATA
        clear_mon();
        feed(0, 32, 0, 1'b1, 14);
        wait_done(300);
        check_frame("t4", 0);
        chk("t4_ferr", 32'(bus.oFrameErr), 32'd1);

        // 5: asynchronous reset mid-DATA
        clear_mon();
        feed(0, 16, 0, 1'b1, -1);
        chk("t5_busy_pre", 32'(bus.oBusy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_valid_async", 32'(bus.oValid), 32'd0);
        chk("t5_busy_async", 32'(bus.oBusy), 32'd0);
        chk("t5_ferr_cleared", 32'(bus.oFrameErr), 32'd0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        clear_mon();
        feed(0, 32, 0, 1'b1, -1);
        wait_done(300);
        check_frame("t5", 0);

        // 6: next-frame pixels arrive during drain of the current frame
        clear_mon();
        feed(0, 32, 0, 1'b1, -1);
        begin
            int g;
            g = 0;
            while (q.size() < 61 && g < 300) begin
                tick();
                g++;
            end
        end
        chk("t6_reach_drain", 32'(q.size() >= 61), 32'd1);
        feed(100, 32, 0, 1'b0, -1);
        wait_done(300);
        check_frame("t6a", 0);
        clear_mon();
        bus.newFrame = 1'b1;
        tick();
        bus.newFrame = 1'b0;
        wait_done(300);
        check_frame("t6b", 100);

        // 3: 4-entry FIFO overrun, sticky until reset
        for (int i = 0; i < 32; i++) begin
            bus2.iValid   = 1'b1;
            bus2.iData    = 24'(i + 1);
            bus2.newFrame = (i == 2);
            tick();
        end
        bus2.iValid   = 1'b0;
        bus2.newFrame = 1'b0;
        chk("t3_ovf", 32'(bus2.oOverflow), 32'd1);
        repeat (20) tick();
        chk("t3_ovf_sticky", 32'(bus2.oOverflow), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t3_ovf_reset", 32'(bus2.oOverflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
